// File: rtl/calc_core.sv
// Calculator arithmetic core: latches two 4-bit operands under key control, applies the
// selected operation and scans the signed decimal result onto a 4-digit common-anode display.
module calc_core #(
    parameter int unsigned REFRESH_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  in_number,
    input  logic [3:0]  arif,
    input  logic [1:0]  key,
    output logic [3:0]  anodes,
    output logic [7:0]  segments,
    output logic [10:0] result,
    output logic        err
);

    localparam int unsigned CNT_W = $clog2(REFRESH_CYCLES + 1);

    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_R     = 8'hAF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV
    } op_t;

    logic [1:0]       key_s1, key_s2, key_prev;
    logic [3:0]       arif_s1, arif_s2;
    logic [1:0]       settle;
    logic [3:0]       op_a, op_b;
    logic             show_ops;
    logic [1:0]       digit_idx;
    logic [CNT_W-1:0] refresh_cnt;

    logic [1:0]  key_fall;
    logic        load_a, load_b;
    op_t         op_sel;
    logic [10:0] nxt_result;
    logic        nxt_err;
    logic [10:0] mag;
    logic [3:0]  hund, tens, units;
    logic [7:0]  dseg [4];

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = 8'hC0;
            4'd1:    seg_digit = 8'hF9;
            4'd2:    seg_digit = 8'hA4;
            4'd3:    seg_digit = 8'hB0;
            4'd4:    seg_digit = 8'h99;
            4'd5:    seg_digit = 8'h92;
            4'd6:    seg_digit = 8'h82;
            4'd7:    seg_digit = 8'hF8;
            4'd8:    seg_digit = 8'h80;
            4'd9:    seg_digit = 8'h90;
            default: seg_digit = SEG_BLANK;
        endcase
    endfunction

    // Loads stay blocked until the synchronizers have carried real key levels through,
    // so a key already held low at reset release never registers as a falling edge.
    assign key_fall = key_prev & ~key_s2;
    assign load_a   = (settle == 2'd3) && key_fall[0] && key_s2[1];
    assign load_b   = (settle == 2'd3) && key_fall[1] && key_s2[0];

    always_comb begin
        op_sel = OP_NONE;
        if (!arif_s2[0])      op_sel = OP_ADD;
        else if (!arif_s2[1]) op_sel = OP_SUB;
        else if (!arif_s2[2]) op_sel = OP_MUL;
        else if (!arif_s2[3]) op_sel = OP_DIV;
    end

    always_comb begin
        nxt_result = '0;
        nxt_err    = 1'b0;
        case (op_sel)
            OP_ADD: nxt_result = {7'b0, op_a} + {7'b0, op_b};
            OP_SUB: nxt_result = {7'b0, op_a} - {7'b0, op_b};
            OP_MUL: nxt_result = {7'b0, op_a} * {7'b0, op_b};
            OP_DIV: begin
                if (op_b == 4'd0) nxt_err = 1'b1;
                else              nxt_result = {7'b0, op_a / op_b};
            end
            default: nxt_result = '0;
        endcase
    end

    always_comb begin
        mag   = result[10] ? (~result + 11'd1) : result;
        hund  = 4'(mag / 11'd100);
        tens  = 4'((mag / 11'd10) % 11'd10);
        units = 4'(mag % 11'd10);
        for (int unsigned i = 0; i < 4; i++) dseg[i] = SEG_BLANK;
        if (err) begin
            dseg[3] = SEG_E;
            dseg[2] = SEG_R;
            dseg[1] = SEG_R;
        end else if (show_ops) begin
            if (op_a >= 4'd10) dseg[3] = seg_digit(4'd1);
            dseg[2] = seg_digit((op_a >= 4'd10) ? op_a - 4'd10 : op_a);
            if (op_b >= 4'd10) dseg[1] = seg_digit(4'd1);
            dseg[0] = seg_digit((op_b >= 4'd10) ? op_b - 4'd10 : op_b);
        end else begin
            if (result[10]) dseg[3] = SEG_MINUS;
            if (hund != 4'd0) dseg[2] = seg_digit(hund);
            if (hund != 4'd0 || tens != 4'd0) dseg[1] = seg_digit(tens);
            dseg[0] = seg_digit(units);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1      <= '1;
            key_s2      <= '1;
            key_prev    <= '1;
            arif_s1     <= '1;
            arif_s2     <= '1;
            settle      <= '0;
            op_a        <= '0;
            op_b        <= '0;
            result      <= '0;
            err         <= 1'b0;
            show_ops    <= 1'b1;
            digit_idx   <= '0;
            refresh_cnt <= '0;
            anodes      <= '1;
            segments    <= '1;
        end else begin
            key_s1   <= key;
            key_s2   <= key_s1;
            key_prev <= key_s2;
            arif_s1  <= arif;
            arif_s2  <= arif_s1;
            if (settle != 2'd3) settle <= settle + 2'd1;
            if (load_a) op_a <= in_number;
            if (load_b) op_b <= in_number;
            result   <= nxt_result;
            err      <= nxt_err;
            show_ops <= (op_sel == OP_NONE);
            if (refresh_cnt == CNT_W'(REFRESH_CYCLES - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + CNT_W'(1);
            end
            anodes   <= ~(4'b0001 << digit_idx);
            segments <= dseg[digit_idx];
        end
    end

endmodule

// File: tb/tb_calc_core.sv
// Directed bench for calc_core: operand loading, each operation, priority, key edge rules,
// reset behaviour and the scanned 7-segment output, against hand-computed values.
module tb_calc_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_number;
    logic [3:0]  arif;
    logic [1:0]  key;
    logic [3:0]  anodes;
    logic [7:0]  segments;
    logic [10:0] result;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    calc_core #(.REFRESH_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_number (in_number),
        .arif      (arif),
        .key       (key),
        .anodes    (anodes),
        .segments  (segments),
        .result    (result),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_op(input int which, input logic [3:0] v);
        in_number  = v;
        key[which] = 1'b0;
        step(3);
        key[which] = 1'b1;
        step(4);
    endtask

    // Watches one full scan and compares each digit's segment code (d3..d0 order).
    task automatic check_digits(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                                input logic [7:0] e1, input logic [7:0] e0);
        logic [7:0] got [4];
        logic [7:0] exp [4];
        exp[3] = e3; exp[2] = e2; exp[1] = e1; exp[0] = e0;
        for (int i = 0; i < 4; i++) got[i] = 8'h00;
        step(8);
        for (int c = 0; c < 24; c++) begin
            case (anodes)
                4'b1110: got[0] = segments;
                4'b1101: got[1] = segments;
                4'b1011: got[2] = segments;
                4'b0111: got[3] = segments;
                default: ;
            endcase
            step(1);
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_d%0d", tag, i), int'(got[i]), int'(exp[i]));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; key = 2'b11; arif = 4'b1111; in_number = 4'd0;
        step(2);
        check("rst_anodes", int'(anodes), 'hF);
        check("rst_segments", int'(segments), 'hFF);
        check("rst_result", int'(result), 0);
        check("rst_err", int'(err), 0);

        rst = 1'b0;
        step(1);
        check("scan0_anodes", int'(anodes), 'hE);
        check("scan0_segments", int'(segments), 'hC0);
        step(4);
        check("scan1_anodes", int'(anodes), 'hD);
        step(4);
        check("scan2_anodes", int'(anodes), 'hB);
        step(4);
        check("scan3_anodes", int'(anodes), 'h7);

        // add 9 + 7, with arif-to-result latency of two edges
        load_op(0, 4'd9);
        load_op(1, 4'd7);
        arif = 4'b1110;
        step(2);
        check("add_lat_k1", int'(result), 0);
        step(1);
        check("add_lat_k2", int'(result), 16);
        check_digits("add16", 8'hFF, 8'hFF, 8'hF9, 8'h82);

        // key-to-result latency: A=3 visible in result at edge k+3
        in_number = 4'd3;
        key[0] = 1'b0;
        step(2);
        check("key_lat_k1", int'(result), 16);
        step(1);
        check("key_lat_k2", int'(result), 16);
        step(1);
        check("key_lat_k3", int'(result), 10);
        key[0] = 1'b1;
        step(4);

        load_op(1, 4'd12);
        arif = 4'b1101;
        step(3);
        check("sub_result", int'(result), 'h7F7);
        check("sub_err", int'(err), 0);
        check_digits("sub_m9", 8'hBF, 8'hFF, 8'hFF, 8'h90);

        load_op(0, 4'd15);
        load_op(1, 4'd15);
        arif = 4'b1011;
        step(3);
        check("mul_result", int'(result), 225);
        check_digits("mul225", 8'hFF, 8'hA4, 8'hA4, 8'h92);

        load_op(0, 4'd5);
        load_op(1, 4'd0);
        arif = 4'b0111;
        step(3);
        check("div0_err", int'(err), 1);
        check("div0_result", int'(result), 0);
        check_digits("div0", 8'h86, 8'hAF, 8'hAF, 8'hFF);

        arif = 4'b0110;
        step(3);
        check("prio_result", int'(result), 5);
        check("prio_err", int'(err), 0);

        arif = 4'b0111;
        load_op(1, 4'd4);
        step(1);
        check("div_result", int'(result), 1);
        check("div_err", int'(err), 0);

        // both keys falling together must not load
        arif = 4'b1110;
        step(3);
        check("add_5_4", int'(result), 9);
        in_number = 4'd13;
        key = 2'b00;
        step(5);
        key = 2'b11;
        step(5);
        check("both_keys", int'(result), 9);

        // held key loads once; a later in_number change must not be captured
        in_number = 4'd2;
        key[0] = 1'b0;
        step(10);
        in_number = 4'd6;
        step(90);
        key[0] = 1'b1;
        step(4);
        check("held_key", int'(result), 6);

        load_op(0, 4'd12);
        load_op(1, 4'd4);
        arif = 4'b1111;
        step(3);
        check("noop_result", int'(result), 0);
        check("noop_err", int'(err), 0);
        check_digits("noop", 8'hF9, 8'hA4, 8'hFF, 8'h99);

        // reset mid-operation with key[0] held through release
        arif = 4'b1110;
        in_number = 4'd5;
        key[0] = 1'b0;
        rst = 1'b1;
        step(2);
        check("rst_mid_result", int'(result), 0);
        check("rst_mid_anodes", int'(anodes), 'hF);
        rst = 1'b0;
        step(10);
        check("held_at_rst", int'(result), 0);
        key = 2'b11;
        step(4);
        check("held_at_rst_release", int'(result), 0);
        check("held_at_rst_err", int'(err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
